// File: rtl/sd_dat_pkt_ctrl.sv
// sd_dat_pkt_ctrl
// Receive sequencer for one SD DAT0 data packet:
//   start bit -> BLK_BYTES data bytes -> 16 CRC bits -> end bit.
// Completed bytes are presented on DATASI/PTDATAPNTR with a one-cycle
// sbdone strobe. The strobe and the stage write enables are meant for the
// downstream field parsers.
//
// Optional feature macro: DATCRC_CHECK_EN
//   defined   : a CRC16-CCITT generator runs over the data bits, and the
//               end-bit check also compares the received CRC with it.
//   undefined : no generator is built. The CRC bits are still clocked
//               through, and crcerr reflects the end bit only.

module sd_dat_pkt_ctrl #(
    parameter int TOUT_CYC  = 65535,
    parameter int BLK_BYTES = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdstart,
    input  logic [1:0]  stagesel,
    input  logic        dat,
    output logic [7:0]  DATASI,
    output logic [15:0] PTDATAPNTR,
    output logic        sbdone,
    output logic        mbrprmwe,
    output logic        bpbprmwe,
    output logic        busy,
    output logic        pktdone,
    output logic        crcerr,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE,
        WAITSB,
        DATA,
        CRC,
        ENDB,
        FIN
    } state_t;

    // Last value of the start-bit wait counter before giving up
    localparam logic [15:0] TOUT_LAST = 16'(TOUT_CYC - 1);
    // Byte count held just before the final byte of the packet completes
    localparam logic [15:0] BLK_LAST  = 16'(BLK_BYTES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  bit_cnt;
    logic [3:0]  crc_cnt;
    logic [15:0] tout_cnt;
    logic [1:0]  stage;
    logic        byte_end;
    logic        last_byte;
    logic        crc_bad;

    assign byte_end  = (state == DATA) && (bit_cnt == 3'd7);
    assign last_byte = byte_end && (PTDATAPNTR == BLK_LAST);

    // State register; reset drops any packet in flight straight back to IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; rdstart is only looked at in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rdstart) begin
                    state_nxt = WAITSB;
                end
            end
            WAITSB: begin
                if (!dat) begin
                    state_nxt = DATA;
                end else if (tout_cnt == TOUT_LAST) begin
                    state_nxt = FIN;
                end
            end
            DATA: begin
                if (last_byte) begin
                    state_nxt = CRC;
                end
            end
            CRC: begin
                if (crc_cnt == 4'd15) begin
                    state_nxt = ENDB;
                end
            end
            ENDB: begin
                state_nxt = FIN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State-decoded outputs: busy flag and the per-stage write enables
    always_comb begin
        busy     = (state != IDLE);
        mbrprmwe = (state == DATA) && (stage == 2'd0);
        bpbprmwe = (state == DATA) && (stage == 2'd1);
    end

    // Datapath: counters, shift register, byte strobe, sticky status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            DATASI     <= 8'h00;
            PTDATAPNTR <= 16'h0000;
            sbdone     <= 1'b0;
            pktdone    <= 1'b0;
            crcerr     <= 1'b0;
            timeout    <= 1'b0;
            bit_cnt    <= 3'd0;
            crc_cnt    <= 4'd0;
            tout_cnt   <= 16'h0000;
            stage      <= 2'd0;
        end else begin
            sbdone  <= 1'b0;
            pktdone <= 1'b0;
            case (state)
                IDLE: begin
                    if (rdstart) begin
                        stage      <= stagesel;
                        crcerr     <= 1'b0;
                        timeout    <= 1'b0;
                        bit_cnt    <= 3'd0;
                        PTDATAPNTR <= 16'h0000;
                        crc_cnt    <= 4'd0;
                        tout_cnt   <= 16'h0000;
                    end
                end
                WAITSB: begin
                    if (dat) begin
                        if (tout_cnt == TOUT_LAST) begin
                            timeout <= 1'b1;
                        end else begin
                            tout_cnt <= tout_cnt + 16'd1;
                        end
                    end
                end
                DATA: begin
                    DATASI  <= {DATASI[6:0], dat};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_end) begin
                        PTDATAPNTR <= PTDATAPNTR + 16'd1;
                        sbdone     <= 1'b1;
                    end
                end
                CRC: begin
                    crc_cnt <= crc_cnt + 4'd1;
                end
                ENDB: begin
                    if (!dat || crc_bad) begin
                        crcerr <= 1'b1;
                    end
                end
                FIN: begin
                    pktdone <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DATCRC_CHECK_EN
    logic [15:0] crc_calc;
    logic [15:0] crc_rx;
    logic        crc_fb;

    assign crc_fb  = crc_calc[15] ^ dat;
    assign crc_bad = (crc_rx != crc_calc);

    // CRC16-CCITT over the data bits only, plus capture of the received CRC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_calc <= 16'h0000;
            crc_rx   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (rdstart) begin
                        crc_calc <= 16'h0000;
                        crc_rx   <= 16'h0000;
                    end
                end
                DATA: begin
                    crc_calc <= {crc_calc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
                end
                CRC: begin
                    crc_rx <= {crc_rx[14:0], dat};
                end
                default: begin
                end
            endcase
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

endmodule

// File: tb/tb_sd_dat_pkt_ctrl.sv
// Testbench for sd_dat_pkt_ctrl: table of packet scenarios with random
// payloads, plus hand-written timeout and mid-packet reset sequences.
// Expected CRC comes from a polynomial long-division model of the payload.

module tb_sd_dat_pkt_ctrl;

    localparam int BLK  = 512;
    localparam int TOUT = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rdstart = 1'b0;
    logic [1:0]  stagesel = 2'd0;
    logic        dat = 1'b1;
    logic [7:0]  DATASI;
    logic [15:0] PTDATAPNTR;
    logic        sbdone;
    logic        mbrprmwe;
    logic        bpbprmwe;
    logic        busy;
    logic        pktdone;
    logic        crcerr;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt [BLK];
    logic [7:0] rx [BLK];
    logic       rx_mbr [BLK];

    typedef struct {
        logic [1:0] stage;
        int         pre_idle;
        logic       flip_crc;
        logic       end_bit;
        logic       busy_req;
        logic       exp_crcerr;
        logic       exp_mbr;
        logic       exp_bpb;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    sd_dat_pkt_ctrl #(
        .TOUT_CYC (TOUT),
        .BLK_BYTES(BLK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rdstart   (rdstart),
        .stagesel  (stagesel),
        .dat       (dat),
        .DATASI    (DATASI),
        .PTDATAPNTR(PTDATAPNTR),
        .sbdone    (sbdone),
        .mbrprmwe  (mbrprmwe),
        .bpbprmwe  (bpbprmwe),
        .busy      (busy),
        .pktdone   (pktdone),
        .crcerr    (crcerr),
        .timeout   (timeout)
    );

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random payload; the MBR partition fields are planted when asked
    task automatic fill_pkt(input logic mbr_fields);
        for (int i = 0; i < BLK; i++) begin
            pkt[i] = 8'($urandom);
            rx[i]  = ~pkt[i];
            rx_mbr[i] = 1'b0;
        end
        if (mbr_fields) begin
            pkt[9'h1C2] = 8'h0B;
            pkt[9'h1C6] = 8'h00;
            pkt[9'h1C7] = 8'h08;
            pkt[9'h1C8] = 8'h00;
            pkt[9'h1C9] = 8'h00;
        end
    endtask

    // Remainder of payload(x) * x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] model_crc();
        logic        bits [BLK*8+16];
        logic [16:0] poly;
        logic [15:0] r;
        poly = 17'h11021;
        for (int i = 0; i < BLK*8 + 16; i++) begin
            bits[i] = (i < BLK*8) ? pkt[i/8][7-(i%8)] : 1'b0;
        end
        for (int i = 0; i < BLK*8; i++) begin
            if (bits[i]) begin
                for (int k = 0; k < 17; k++) begin
                    bits[i+k] = bits[i+k] ^ poly[16-k];
                end
            end
        end
        for (int k = 0; k < 16; k++) begin
            r[15-k] = bits[BLK*8+k];
        end
        return r;
    endfunction

    // Drive one packet (or its first abort_bytes bytes) and check it
    task automatic apply_stimulus(input vec_t v, input int abort_bytes);
        logic [15:0] crc;
        int          pulses;
        int          bad_pos;
        int          bad_we;
        int          bad_data;
        int          rel;
        logic        prev_sb;
        pulses   = 0;
        bad_pos  = 0;
        bad_we   = 0;
        bad_data = 0;
        prev_sb  = 1'b0;
        crc = model_crc();
        if (v.flip_crc) crc[5] = ~crc[5];

        stagesel = v.stage;
        rdstart  = 1'b1;
        dat      = 1'b1;
        tick();
        rdstart = 1'b0;
        check_output("busy_after_rdstart", 32'(busy), 32'd1);
        check_output("crcerr_cleared", 32'(crcerr), 32'd0);
        check_output("timeout_cleared", 32'(timeout), 32'd0);
        repeat (v.pre_idle) tick();

        dat = 1'b0;
        tick();
        for (int i = 0; i < BLK*8; i++) begin
            dat = pkt[i/8][7-(i%8)];
            tick();
            rel = i + 1;
            rdstart  = (v.busy_req && rel == 80);
            stagesel = rdstart ? 2'd3 - v.stage : v.stage;
            if (sbdone) begin
                pulses++;
                if ((rel % 8) != 0 || prev_sb) bad_pos++;
                if (PTDATAPNTR != 16'(rel/8)) begin
                    bad_pos++;
                end else begin
                    rx[rel/8-1]     = DATASI;
                    rx_mbr[rel/8-1] = mbrprmwe;
                end
                if (rel < BLK*8 && (mbrprmwe !== v.exp_mbr || bpbprmwe !== v.exp_bpb)) bad_we++;
            end else if ((rel % 8) == 0) begin
                bad_pos++;
            end
            prev_sb = sbdone;
            if (abort_bytes > 0 && rel == abort_bytes*8) begin
                check_output("abort_pulses", 32'(pulses), 32'(abort_bytes));
                check_output("abort_pos", 32'(bad_pos), 32'd0);
                return;
            end
        end
        rdstart  = 1'b0;
        stagesel = v.stage;

        for (int j = 15; j >= 0; j--) begin
            dat = crc[j];
            tick();
            if (sbdone || pktdone) bad_pos++;
        end
        dat = v.end_bit;
        tick();
        check_output("pktdone_early", 32'(pktdone), 32'd0);
        dat = 1'b1;
        tick();
        check_output("pktdone_at_4114", 32'(pktdone), 32'd1);
        check_output("busy_at_end", 32'(busy), 32'd0);
        check_output("crcerr", 32'(crcerr), 32'(v.exp_crcerr));
        check_output("sbdone_pulses", 32'(pulses), 32'(BLK));
        check_output("pulse_pos_errs", 32'(bad_pos), 32'd0);
        check_output("stage_we_errs", 32'(bad_we), 32'd0);
        for (int i = 0; i < BLK; i++) begin
            if (rx[i] !== pkt[i]) bad_data++;
        end
        check_output("byte_errs", 32'(bad_data), 32'd0);
        check_output("ptr_hold", 32'(PTDATAPNTR), 32'(BLK));
        check_output("datasi_hold", 32'(DATASI), 32'(pkt[BLK-1]));
        if (v.stage == 2'd0) begin
            check_output("mbr_1c3_data", 32'(rx[9'h1C2]), 32'h0B);
            check_output("mbr_1c3_we", 32'(rx_mbr[9'h1C2]), 32'd1);
            check_output("mbr_1c7_data", 32'(rx[9'h1C6]), 32'h00);
            check_output("mbr_1c8_data", 32'(rx[9'h1C7]), 32'h08);
        end
        tick();
        check_output("pktdone_one_cycle", 32'(pktdone), 32'd0);
        check_output("crcerr_sticky", 32'(crcerr), 32'(v.exp_crcerr));
    endtask

    // Start-bit never arrives: timeout flag, pktdone one cycle later
    task automatic run_timeout();
        int done_at;
        int sb;
        done_at = -1;
        sb = 0;
        dat = 1'b1;
        stagesel = 2'd2;
        rdstart = 1'b1;
        tick();
        rdstart = 1'b0;
        for (int c = 1; c <= TOUT + 20; c++) begin
            tick();
            if (sbdone) sb++;
            if (c == TOUT) check_output("timeout_set", 32'(timeout), 32'd1);
            if (pktdone) begin
                done_at = c;
                break;
            end
        end
        check_output("timeout_pktdone_cycle", 32'(done_at), 32'(TOUT + 1));
        check_output("timeout_no_sbdone", 32'(sb), 32'd0);
        check_output("timeout_busy", 32'(busy), 32'd0);
        check_output("timeout_crcerr", 32'(crcerr), 32'd0);
    endtask

    initial begin
        logic exp_flip;
        int   late_done;
`ifdef DATCRC_CHECK_EN
        exp_flip = 1'b1;
`else
        exp_flip = 1'b0;
`endif
        vecs[0] = '{2'd0, $urandom_range(0, 20), 1'b0, 1'b1, 1'b0, 1'b0,     1'b1, 1'b0};
        vecs[1] = '{2'd0, $urandom_range(0, 20), 1'b1, 1'b1, 1'b0, exp_flip, 1'b1, 1'b0};
        vecs[2] = '{2'd0, $urandom_range(0, 20), 1'b0, 1'b0, 1'b0, 1'b1,     1'b1, 1'b0};
        vecs[3] = '{2'd1, $urandom_range(0, 20), 1'b0, 1'b1, 1'b1, 1'b0,     1'b0, 1'b1};
        vecs[4] = '{2'd2, $urandom_range(0, 20), 1'b0, 1'b1, 1'b1, 1'b0,     1'b0, 1'b0};
        vecs[5] = '{2'd3, $urandom_range(0, 20), 1'b1, 1'b0, 1'b0, 1'b1,     1'b0, 1'b0};

        reset = 1'b0;
        repeat (3) tick();
        check_output("rst_datasi", 32'(DATASI), 32'h00);
        check_output("rst_ptr", 32'(PTDATAPNTR), 32'h0);
        check_output("rst_flags", 32'({sbdone, mbrprmwe, bpbprmwe, busy, pktdone, crcerr, timeout}), 32'h0);
        reset = 1'b1;
        tick();

        for (int n = 0; n < 3; n++) begin
            fill_pkt(vecs[n].stage == 2'd0);
            apply_stimulus(vecs[n], 0);
        end

        run_timeout();

        // Abort a stage-0 packet at byte 200 with reset
        fill_pkt(1'b1);
        apply_stimulus(vecs[0], 200);
        #2;
        reset = 1'b0;
        #1;
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_ptr", 32'(PTDATAPNTR), 32'd0);
        check_output("midrst_datasi", 32'(DATASI), 32'h00);
        check_output("midrst_we", 32'({mbrprmwe, sbdone}), 32'd0);
        rdstart = 1'b0;
        dat = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        late_done = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (pktdone || busy) late_done++;
        end
        check_output("midrst_no_pktdone", 32'(late_done), 32'd0);

        for (int n = 3; n < 6; n++) begin
            fill_pkt(vecs[n].stage == 2'd0);
            apply_stimulus(vecs[n], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
